// File: rtl/bypass_scoreboard_pkg.sv
// Shared constants and scoreboard entry layout for the bypass/hazard controller.
package bypass_scoreboard_pkg;

  // fwd_sel value meaning "take the operand from the register file"
  localparam int FWD_RF = 0;

  // Per-entry status bits; the destination register is kept alongside at width AW.
  typedef struct packed {
    logic valid;
    logic we;
    logic is_load;
  } ent_flags_t;

  localparam int ENT_FLAG_W = $bits(ent_flags_t);

  function automatic int ent_width(input int aw);
    return ENT_FLAG_W + aw;
  endfunction

  // Select width covers 0 (regfile) through DEPTH (writeback delay register).
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bypass_scoreboard_fwd_match.sv
// Youngest-match priority encoder for one decode source against all scoreboard entries.
module bypass_scoreboard_fwd_match
  import bypass_scoreboard_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int IDXW  = 2
) (
  input  logic [AW-1:0]   rs,
  input  logic            rs_used,
  input  logic            id_valid,
  input  ent_flags_t      flags [DEPTH],
  input  logic [AW-1:0]   rd [DEPTH],
  output logic            hit,
  output logic [IDXW-1:0] idx,
  output logic            is_load
);

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (id_valid && rs_used && (rs != '0) &&
          flags[i].valid && flags[i].we && (rd[i] == rs)) begin
        hit     = 1'b1;
        idx     = IDXW'(i);
        is_load = flags[i].is_load;
      end
    end
  end

endmodule

// File: rtl/bypass_scoreboard.sv
// Hazard/bypass controller: scoreboard of in-flight writers, load-use stall, redirect kill.
// Optional cycle counters for stall/kill are built when BYPASS_SCOREBOARD_PERF_EN is defined.
module bypass_scoreboard
  import bypass_scoreboard_pkg::*;
#(
  parameter int  NUM_SRC     = 2,
  parameter int  AW          = 5,
  parameter int  DEPTH       = 3,
  parameter int  LOAD_STAGE  = 2,
  parameter int  KILL_CYCLES = 1,
  localparam int SELW        = sel_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic                    id_we,
  input  logic                    id_is_load,
  input  logic [AW-1:0]           id_rd,
  input  logic [NUM_SRC*AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic                    ex_redirect,
  output logic                    stall,
  output logic                    kill,
  output logic [NUM_SRC*SELW-1:0] fwd_sel
`ifdef BYPASS_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             kill_cnt
`endif
);

  localparam int IDXW = idx_width(DEPTH);
  localparam int KCW  = $clog2(KILL_CYCLES + 1);

  ent_flags_t          flags_q [DEPTH];
  logic [AW-1:0]       rd_q    [DEPTH];
  logic [KCW-1:0]      kcnt_q;

  logic [NUM_SRC-1:0]  hit;
  logic [NUM_SRC-1:0]  hit_load;
  logic [IDXW-1:0]     hit_idx [NUM_SRC];

  logic                redirect_ok;
  logic                kill_i;
  logic                stall_raw;
  logic                stall_i;
  logic [NUM_SRC*SELW-1:0] fwd_next;

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    bypass_scoreboard_fwd_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .IDXW  (IDXW)
    ) u_match (
      .rs       (id_rs[n*AW +: AW]),
      .rs_used  (id_rs_used[n]),
      .id_valid (id_valid),
      .flags    (flags_q),
      .rd       (rd_q),
      .hit      (hit[n]),
      .idx      (hit_idx[n]),
      .is_load  (hit_load[n])
    );
  end

  // A redirect from a bubble in X is meaningless, so it only counts with a live entry 0.
  assign redirect_ok = ex_redirect && flags_q[0].valid;
  assign kill_i      = redirect_ok || (kcnt_q != '0);

  always_comb begin
    stall_raw = 1'b0;
    for (int n = 0; n < NUM_SRC; n++) begin
      if (hit[n] && hit_load[n] && ((int'(hit_idx[n]) + 1) < LOAD_STAGE)) begin
        stall_raw = 1'b1;
      end
    end
  end

  // A killed decode instruction needs no operands, so kill masks the stall.
  assign stall_i = stall_raw && !kill_i;
  assign stall   = stall_i;
  assign kill    = kill_i;

  always_comb begin
    fwd_next = {NUM_SRC{SELW'(FWD_RF)}};
    if (!stall_i && !kill_i) begin
      for (int n = 0; n < NUM_SRC; n++) begin
        if (hit[n]) begin
          fwd_next[n*SELW +: SELW] = SELW'(int'(hit_idx[n]) + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        flags_q[i] <= '0;
        rd_q[i]    <= '0;
      end
      fwd_sel <= '0;
      kcnt_q  <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        flags_q[i] <= flags_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
      if (stall_i || kill_i) begin
        flags_q[0] <= '0;
        rd_q[0]    <= '0;
      end else begin
        flags_q[0] <= '{valid: id_valid, we: id_we, is_load: id_is_load};
        rd_q[0]    <= id_rd;
      end
      fwd_sel <= fwd_next;
      if (redirect_ok) begin
        kcnt_q <= KCW'(KILL_CYCLES - 1);
      end else if (kcnt_q != '0) begin
        kcnt_q <= kcnt_q - KCW'(1);
      end
    end
  end

`ifdef BYPASS_SCOREBOARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (stall_i && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (kill_i && (kill_cnt != '1)) begin
        kill_cnt <= kill_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed-vector bench for bypass_scoreboard with a queue-based scoreboard monitor.
module tb_bypass_scoreboard;

  localparam int NUM_SRC     = 2;
  localparam int AW          = 5;
  localparam int DEPTH       = 3;
  localparam int LOAD_STAGE  = 2;
  localparam int KILL_CYCLES = 2;
  localparam int SELW        = 2;
  localparam int FW          = NUM_SRC * SELW;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  id_valid = 1'b0;
  logic                  id_we = 1'b0;
  logic                  id_is_load = 1'b0;
  logic [AW-1:0]         id_rd = '0;
  logic [NUM_SRC*AW-1:0] id_rs = '0;
  logic [NUM_SRC-1:0]    id_rs_used = '0;
  logic                  ex_redirect = 1'b0;
  logic                  stall;
  logic                  kill;
  logic [FW-1:0]         fwd_sel;
`ifdef BYPASS_SCOREBOARD_PERF_EN
  logic [31:0]           stall_cnt;
  logic [31:0]           kill_cnt;
`endif

  always #5 clk = ~clk;

  bypass_scoreboard #(
    .NUM_SRC     (NUM_SRC),
    .AW          (AW),
    .DEPTH       (DEPTH),
    .LOAD_STAGE  (LOAD_STAGE),
    .KILL_CYCLES (KILL_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .id_rd       (id_rd),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .kill        (kill),
    .fwd_sel     (fwd_sel)
`ifdef BYPASS_SCOREBOARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .kill_cnt    (kill_cnt)
`endif
  );

  typedef struct {
    string         name;
    bit            s;
    bit            k;
    logic [FW-1:0] f;
    bit            cp;
    int            sc;
    int            kc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event sample_ev;

  always @(negedge clk) -> sample_ev;

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (stall !== e.s || kill !== e.k || fwd_sel !== e.f) begin
          miscompares++;
          $display("FAIL %s: got stall=%0b kill=%0b fwd_sel=%h, want stall=%0b kill=%0b fwd_sel=%h",
                   e.name, stall, kill, fwd_sel, e.s, e.k, e.f);
        end
`ifdef BYPASS_SCOREBOARD_PERF_EN
        if (e.cp) begin
          vectors++;
          if (stall_cnt !== 32'(e.sc) || kill_cnt !== 32'(e.kc)) begin
            miscompares++;
            $display("FAIL %s_perf: got stall_cnt=%0d kill_cnt=%0d, want stall_cnt=%0d kill_cnt=%0d",
                     e.name, stall_cnt, kill_cnt, e.sc, e.kc);
          end
        end
`endif
      end
    end
  end

  task automatic push(input string name, input bit s, input bit k, input logic [FW-1:0] f,
                      input bit cp, input int sc, input int kc);
    exp_t e;
    e.name = name; e.s = s; e.k = k; e.f = f; e.cp = cp; e.sc = sc; e.kc = kc;
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input bit v, input bit we, input bit ld,
                      input int rd, input int rs0, input int rs1, input bit [1:0] used,
                      input bit redir, input bit es, input bit ek, input logic [FW-1:0] ef,
                      input bit cp = 1'b0, input int sc = 0, input int kc = 0);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_we       = we;
    id_is_load  = ld;
    id_rd       = AW'(rd);
    id_rs       = {AW'(rs1), AW'(rs0)};
    id_rs_used  = used;
    ex_redirect = redir;
    push(name, es, ek, ef, cp, sc, kc);
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      step("flush", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // reset held: a redirect request must not produce kill
    @(posedge clk);
    #1;
    ex_redirect = 1'b1;
    push("reset_hold", 0, 0, 4'h0, 1, 0, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'h0);
    flush(3);

    // ALU -> ALU back-to-back forwards from entry 0 on both sources
    step("alu_addi_x5", 1, 1, 0, 5, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("alu_add_x6",  1, 1, 0, 6, 5, 5, 2'b11, 0, 0, 0, 4'h0);
    step("alu_fwd_x",   0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h5);
    step("alu_after",   0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    flush(2);

    // load-use: one stall cycle, then forward from entry 1
    step("lu_lw_x7",    1, 1, 1, 7, 1, 0, 2'b01, 0, 0, 0, 4'h0);
    step("lu_stall",    1, 1, 0, 8, 7, 1, 2'b11, 0, 1, 0, 4'h0);
    step("lu_release",  1, 1, 0, 8, 7, 1, 2'b11, 0, 0, 0, 4'h0);
    step("lu_fwd_x",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h2);
    step("lu_after",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    flush(2);

    // writes to x0 are never forwarded
    step("x0_addi",     1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("x0_add_x9",   1, 1, 0, 9, 0, 0, 2'b11, 0, 0, 0, 4'h0);
    step("x0_fwd_x",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    flush(3);

    // two writers to x9: the younger one wins
    step("yw_w1_x9",    1, 1, 0, 9, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("yw_w2_x9",    1, 1, 0, 9, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("yw_reader",   1, 1, 0, 10, 9, 9, 2'b11, 0, 0, 0, 4'h0);
    step("yw_fwd_x",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h5);
    step("yw_after",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    flush(3);

    // match in the oldest entry selects the writeback delay register; unused source ignored
    step("wb_addi_x11", 1, 1, 0, 11, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("wb_gap1",     0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    step("wb_gap2",     0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    step("wb_reader",   1, 0, 0, 0, 11, 11, 2'b01, 0, 0, 0, 4'h0);
    step("wb_fwd_x",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h3);
    step("wb_after",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    flush(3);

    // redirect with a live X instruction: two kill cycles, operands suppressed
    step("rd_i1",       1, 1, 0, 12, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("rd_kill1",    1, 1, 0, 13, 12, 0, 2'b01, 1, 0, 1, 4'h0);
    step("rd_kill2",    1, 1, 0, 14, 12, 0, 2'b01, 0, 0, 1, 4'h0);
    step("rd_bubble_x", 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'h0);
    step("rd_idle",     0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);

    // kill masks a simultaneous load-use stall
    step("ks_lw_x15",   1, 1, 1, 15, 1, 0, 2'b01, 0, 0, 0, 4'h0);
    step("ks_kill",     1, 1, 0, 16, 15, 0, 2'b01, 1, 0, 1, 4'h0);
    step("ks_kill2",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 4'h0);
    step("ks_done",     0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);
    flush(3);

    // reset asserted in the middle of a stall cycle
    step("mr_addi_x21", 1, 1, 0, 21, 0, 0, 2'b01, 0, 0, 0, 4'h0);
    step("mr_lw_x20",   1, 1, 1, 20, 21, 0, 2'b01, 0, 0, 0, 4'h0);
    step("mr_stall",    1, 1, 0, 22, 20, 0, 2'b01, 0, 1, 0, 4'h1, 1, 1, 4);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    push("reset_mid_stall", 0, 0, 4'h0, 1, 0, 0);
    -> sample_ev;
    @(negedge clk);
    reset = 1'b0;
    step("mr_post",     1, 1, 0, 22, 20, 0, 2'b01, 0, 0, 0, 4'h0, 1, 0, 0);
    step("mr_final",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
